h_rng_sampler: RTL and testbench

//  Upstream feeder of the sparse-h generator: fetches raw RNG_DAT_W-bit words from the PRNG and rejection-samples
//  H_DAT_W-bit candidates against r, one candidate per LANE_W-bit lane.

---
 rtl/h_rng_sampler_if.sv | 41 ++++
 rtl/h_rng_sampler.sv | 201 ++++++++++++++++++++
 tb/tb_h_rng_sampler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/h_rng_sampler_if.sv
// rtl/h_rng_sampler_if.sv - PRNG fetch and RNG FIFO write signals of the h_rng_sampler
//
// Purpose: bundles the two handshakes of the sampler so the top can take one
// bus port. The sampler is the master: it requests raw words from the PRNG
// and writes packed candidate pairs into the RNG FIFO.
//
// Signals:
//   prng_req   master->slave  request a raw word; transfer on prng_req && prng_valid
//   prng_valid slave->master  raw word valid
//   prng_din   slave->master  raw random word
//   fifo_wr    master->slave  one-cycle write strobe
//   fifo_dout  master->slave  packed pair {.., c2 in lane 1, c1 in lane 0}
//   fifo_full  slave->master  FIFO full; no write is issued while high
interface h_rng_sampler_if #(
    parameter int RNG_DAT_W = 64
);
    logic                 prng_req;
    logic                 prng_valid;
    logic [RNG_DAT_W-1:0] prng_din;
    logic                 fifo_wr;
    logic [RNG_DAT_W-1:0] fifo_dout;
    logic                 fifo_full;

    modport master (
        output prng_req,
        input  prng_valid,
        input  prng_din,
        output fifo_wr,
        output fifo_dout,
        input  fifo_full
    );

    modport slave (
        input  prng_req,
        output prng_valid,
        output prng_din,
        input  fifo_wr,
        input  fifo_dout,
        output fifo_full
    );
endinterface

// File: rtl/h_rng_sampler.sv
// rtl/h_rng_sampler.sv - rejection sampler packing two distinct positions < r per RNG FIFO word
//
// Purpose: fetches raw RNG_DAT_W-bit words from the PRNG, takes the low
// H_DAT_W bits of each LANE_W-bit lane as a candidate, rejects candidates
// that are >= r or equal to the already held first candidate, and writes
// accepted pairs to the RNG FIFO as {.., c2 @ lane 1, c1 @ lane 0}.
//
// Ports:
//   clk        in   clock
//   rst_b      in   synchronous reset, active-low
//   rng_start  in   run enable; any nonzero value runs, 0 aborts to idle
//   bus        if   master side of h_rng_sampler_if (PRNG fetch + FIFO write)
//   rej_cnt    out  saturating count of rejected candidates since leaving idle
//
// All outputs come straight from flops.
module h_rng_sampler #(
    parameter int r         = 11027,
    parameter int RNG_DAT_W = 64,
    parameter int LANE_W    = 16,
    parameter int H_DAT_W   = 14
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic [1:0]             rng_start,
    h_rng_sampler_if.master        bus,
    output logic [15:0]            rej_cnt
);

    localparam int N_LANES = RNG_DAT_W / LANE_W;
    // Index runs 0..N_LANES; N_LANES means "every lane of this word used".
    localparam int LANE_IW = $clog2(N_LANES + 1);
    localparam int LANE_SW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int unsigned R_LIMIT = r;
    localparam logic [LANE_IW-1:0] LAST_LANE = LANE_IW'(N_LANES - 1);
    localparam logic [LANE_IW-1:0] END_LANE  = LANE_IW'(N_LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SCAN,
        S_EMIT
    } state_t;

    state_t                           state_q, state_d;
    logic [LANE_IW-1:0]               idx_q, idx_d;
    // Only the candidate bits of each lane are kept; the upper lane bits never matter.
    logic [N_LANES-1:0][H_DAT_W-1:0]  cand_q, cand_d;
    logic                             slot_q, slot_d;
    logic [H_DAT_W-1:0]               c1_q, c1_d;
    logic                             prng_req_q, prng_req_d;
    logic                             fifo_wr_q, fifo_wr_d;
    logic [RNG_DAT_W-1:0]             fifo_dout_q, fifo_dout_d;
    logic [15:0]                      rej_cnt_q, rej_cnt_d;

    logic                             run;
    logic [H_DAT_W-1:0]               cand;
    logic                             cand_rej;
    logic                             to_emit;
    logic [15:0]                      rej_inc;
    logic [RNG_DAT_W-1:0]             packed_w;
    logic [N_LANES-1:0]               unused_lane_hi;

    assign run = |rng_start;

    // SCAN only ever runs with idx_q < N_LANES, so the narrowed select is safe.
    assign cand = cand_q[idx_q[LANE_SW-1:0]];

    assign cand_rej = (32'(cand) >= R_LIMIT) || (slot_q && (cand == c1_q));

    assign rej_inc = (rej_cnt_q == 16'hFFFF) ? rej_cnt_q : rej_cnt_q + 16'd1;

    always_comb begin
        packed_w                     = '0;
        packed_w[H_DAT_W-1:0]        = c1_q;
        packed_w[LANE_W +: H_DAT_W]  = cand;
    end

    genvar g;
    generate
        for (g = 0; g < N_LANES; g++) begin : g_lane_hi
            if (LANE_W > H_DAT_W) begin : g_hi
                assign unused_lane_hi[g] = ^bus.prng_din[g*LANE_W+H_DAT_W +: LANE_W-H_DAT_W];
            end else begin : g_no_hi
                assign unused_lane_hi[g] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cand_d      = cand_q;
        slot_d      = slot_q;
        c1_d        = c1_q;
        prng_req_d  = prng_req_q;
        fifo_wr_d   = 1'b0;
        fifo_dout_d = fifo_dout_q;
        rej_cnt_d   = rej_cnt_q;
        to_emit     = 1'b0;

        if ((state_q != S_IDLE) && !run) begin
            // Abort: drop any half-built pair and the rest of the word; rej_cnt is kept.
            state_d    = S_IDLE;
            idx_d      = '0;
            slot_d     = 1'b0;
            prng_req_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d    = S_FETCH;
                        prng_req_d = 1'b1;
                        rej_cnt_d  = '0;
                    end
                end

                S_FETCH: begin
                    if (prng_req_q && bus.prng_valid) begin
                        for (int i = 0; i < N_LANES; i++) begin
                            cand_d[i] = bus.prng_din[i*LANE_W +: H_DAT_W];
                        end
                        prng_req_d = 1'b0;
                        idx_d      = '0;
                        state_d    = S_SCAN;
                    end
                end

                S_SCAN: begin
                    idx_d = idx_q + LANE_IW'(1);
                    if (cand_rej) begin
                        rej_cnt_d = rej_inc;
                    end else if (!slot_q) begin
                        c1_d   = cand;
                        slot_d = 1'b1;
                    end else begin
                        // The pair is packed now; the slot is free for the next pair.
                        to_emit     = 1'b1;
                        fifo_dout_d = packed_w;
                        fifo_wr_d   = !bus.fifo_full;
                        slot_d      = 1'b0;
                        state_d     = S_EMIT;
                    end
                    // A lone pending c1 survives into the next word.
                    if (!to_emit && (idx_q == LAST_LANE)) begin
                        state_d    = S_FETCH;
                        prng_req_d = 1'b1;
                    end
                end

                S_EMIT: begin
                    if (fifo_wr_q) begin
                        // The strobe is on the bus this cycle; move on.
                        if (idx_q == END_LANE) begin
                            state_d    = S_FETCH;
                            prng_req_d = 1'b1;
                        end else begin
                            state_d = S_SCAN;
                        end
                    end else begin
                        // Waiting on a full FIFO; fifo_dout holds the pair.
                        fifo_wr_d = !bus.fifo_full;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cand_q      <= '0;
            slot_q      <= 1'b0;
            c1_q        <= '0;
            prng_req_q  <= 1'b0;
            fifo_wr_q   <= 1'b0;
            fifo_dout_q <= '0;
            rej_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cand_q      <= cand_d;
            slot_q      <= slot_d;
            c1_q        <= c1_d;
            prng_req_q  <= prng_req_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_dout_q <= fifo_dout_d;
            rej_cnt_q   <= rej_cnt_d;
        end
    end

    assign bus.prng_req  = prng_req_q;
    assign bus.fifo_wr   = fifo_wr_q;
    assign bus.fifo_dout = fifo_dout_q;
    assign rej_cnt       = rej_cnt_q;

endmodule

// File: tb/tb_h_rng_sampler.sv
// tb/tb_h_rng_sampler.sv - directed vector bench for h_rng_sampler
module tb_h_rng_sampler;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [1:0]  rng_start;
    logic [15:0] rej_cnt;

    always #5 clk = ~clk;

    h_rng_sampler_if #(.RNG_DAT_W(64)) bus ();

    h_rng_sampler #(
        .r         (11027),
        .RNG_DAT_W (64),
        .LANE_W    (16),
        .H_DAT_W   (14)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .rng_start (rng_start),
        .bus       (bus),
        .rej_cnt   (rej_cnt)
    );

    typedef struct {
        logic [63:0] din;
        int          n_wr;
        logic [63:0] w0;
        logic [63:0] w1;
        logic [15:0] rej;
    } vec_t;

    vec_t        vecs [9];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] wr_q [$];

    always @(negedge clk) begin
        if (bus.fifo_wr === 1'b1) wr_q.push_back(bus.fifo_dout);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] wr_at(input int k);
        if (k < wr_q.size()) return wr_q[k];
        return 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    // Waits (bounded) for a request, then offers one word for exactly one cycle.
    task automatic feed(input logic [63:0] din, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.prng_req === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " prng_req seen"}, 64'(got), 64'd1);
        bus.prng_valid = 1'b1;
        bus.prng_din   = din;
        @(negedge clk);
        bus.prng_valid = 1'b0;
    endtask

    initial begin
        logic ok_wr, ok_dout;

        vecs[0] = '{64'h0000_0000_0007_0005, 1, 64'h0000_0000_0007_0005, 64'h0, 16'd1};
        vecs[1] = '{64'h2B13_2B12_0002_0001, 1, 64'h0000_0000_0002_0001, 64'h0, 16'd1};
        vecs[2] = '{64'h8000_4003_FFFF_C001, 1, 64'h0000_0000_0003_0001, 64'h0, 16'd1};
        vecs[3] = '{64'h0020_0010_0010_0010, 1, 64'h0000_0000_0020_0010, 64'h0, 16'd2};
        vecs[4] = '{64'h0004_0003_0002_0001, 2, 64'h0000_0000_0002_0001, 64'h0000_0000_0004_0003, 16'd0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0, 64'h0, 16'd4};
        vecs[6] = '{64'h2B12_2B12_2B12_2B12, 0, 64'h0, 64'h0, 16'd3};
        vecs[7] = '{64'hC000_8001_4000_0001, 2, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 16'd0};
        vecs[8] = '{64'h2B12_0000_2B12_2B11, 2, 64'h0000_0000_2B12_2B11, 64'h0000_0000_2B12_0000, 16'd0};

        rst_b          = 1'b0;
        rng_start      = 2'd0;
        bus.prng_valid = 1'b0;
        bus.prng_din   = '0;
        bus.fifo_full  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset prng_req", 64'(bus.prng_req), 64'd0);
        check("reset fifo_wr", 64'(bus.fifo_wr), 64'd0);
        check("reset fifo_dout", bus.fifo_dout, 64'd0);
        check("reset rej_cnt", 64'(rej_cnt), 64'd0);
        rst_b = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            wr_q.delete();
            rng_start = 2'(i % 3 + 1);
            @(negedge clk);
            check({tag, " rej_cnt cleared on start"}, 64'(rej_cnt), 64'd0);
            feed(vecs[i].din, tag);
            repeat (14) @(negedge clk);
            check({tag, " write count"}, 64'(wr_q.size()), 64'(vecs[i].n_wr));
            if (vecs[i].n_wr >= 1) check({tag, " word0"}, wr_at(0), vecs[i].w0);
            if (vecs[i].n_wr >= 2) check({tag, " word1"}, wr_at(1), vecs[i].w1);
            check({tag, " rej_cnt"}, 64'(rej_cnt), 64'(vecs[i].rej));
            rng_start = 2'd0;
            repeat (2) @(negedge clk);
            check({tag, " rej_cnt holds after abort"}, 64'(rej_cnt), 64'(vecs[i].rej));
            check({tag, " prng_req low in idle"}, 64'(bus.prng_req), 64'd0);
        end

        // Latency: lanes at t+1.., write one cycle after the second accept.
        wr_q.delete();
        rng_start = 2'd1;
        @(negedge clk);
        feed(64'h0004_0003_0002_0001, "lat");
        @(negedge clk); check("lat N1 wr", 64'(bus.fifo_wr), 64'd0);
        @(negedge clk); check("lat N2 wr", 64'(bus.fifo_wr), 64'd1);
        check("lat N2 dout", bus.fifo_dout, 64'h0000_0000_0002_0001);
        @(negedge clk); check("lat N3 wr", 64'(bus.fifo_wr), 64'd0);
        @(negedge clk); check("lat N4 wr", 64'(bus.fifo_wr), 64'd0);
        @(negedge clk); check("lat N5 wr", 64'(bus.fifo_wr), 64'd1);
        check("lat N5 dout", bus.fifo_dout, 64'h0000_0000_0004_0003);
        rng_start = 2'd0;
        repeat (2) @(negedge clk);

        // Backpressure: pair waits under fifo_full, written once after it drops.
        wr_q.delete();
        rng_start = 2'd1;
        @(negedge clk);
        bus.fifo_full = 1'b1;
        feed(64'h0004_0003_0002_0001, "bp");
        ok_wr   = 1'b1;
        ok_dout = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (bus.fifo_wr !== 1'b0) ok_wr = 1'b0;
            if (j >= 1 && bus.fifo_dout !== 64'h0000_0000_0002_0001) ok_dout = 1'b0;
        end
        check("bp no write while full", 64'(ok_wr), 64'd1);
        check("bp dout stable while full", 64'(ok_dout), 64'd1);
        bus.fifo_full = 1'b0;
        @(negedge clk);
        check("bp write after full drops", 64'(bus.fifo_wr), 64'd1);
        repeat (8) @(negedge clk);
        check("bp write count", 64'(wr_q.size()), 64'd2);
        check("bp word0", wr_at(0), 64'h0000_0000_0002_0001);
        check("bp word1", wr_at(1), 64'h0000_0000_0004_0003);
        rng_start = 2'd0;
        repeat (2) @(negedge clk);

        // Abort with c1 pending: nothing written, restart pairs only new lanes.
        wr_q.delete();
        rng_start = 2'd1;
        @(negedge clk);
        feed(64'h0000_0000_FFFF_0005, "abort");
        @(negedge clk);
        rng_start = 2'd0;
        @(negedge clk);
        check("abort prng_req", 64'(bus.prng_req), 64'd0);
        check("abort rej_cnt", 64'(rej_cnt), 64'd0);
        repeat (3) @(negedge clk);
        check("abort no write", 64'(wr_q.size()), 64'd0);
        bus.prng_valid = 1'b1;
        bus.prng_din   = 64'h0000_0000_0009_0008;
        @(negedge clk);
        check("idle ignores prng_valid", 64'(bus.prng_req), 64'd0);
        bus.prng_valid = 1'b0;
        rng_start = 2'd2;
        @(negedge clk);
        feed(64'h0000_0000_0009_0008, "restart");
        repeat (10) @(negedge clk);
        check("restart write count", 64'(wr_q.size()), 64'd1);
        check("restart word0", wr_at(0), 64'h0000_0000_0009_0008);
        check("restart rej_cnt", 64'(rej_cnt), 64'd1);

        // Reset mid-operation clears rej_cnt and drops the request.
        rng_start = 2'd0;
        repeat (2) @(negedge clk);
        rng_start = 2'd3;
        @(negedge clk);
        feed(64'hFFFF_FFFF_FFFF_FFFF, "midrst");
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("midrst rej_cnt", 64'(rej_cnt), 64'd0);
        check("midrst prng_req", 64'(bus.prng_req), 64'd0);
        rst_b     = 1'b1;
        rng_start = 2'd0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
